// File: rtl/mimo_pkg.sv
// Shared sizing, FSM states and schedule lengths for the MMSE pre-calculation block.
package mimo_pkg;
  localparam int DATA_W = 32;
  localparam int N      = 4;
  localparam int A_LEN  = 40;  // upper-triangle H^T*H: 10 entries x 4 products
  localparam int B_LEN  = 16;  // H^T*r: 4 entries x 4 products

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate; o_sum is the value the accumulator takes on this edge.
module mac_unit #(
  parameter int DATA_W = mimo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  // Product and sum both wrap modulo 2^DATA_W.
  assign w_prod = i_a * i_b;
  assign o_sum  = (i_clr ? '0 : r_acc) + w_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_acc <= '0;
    else if (i_en) r_acc <= o_sum;
  end
endmodule

// File: rtl/mmse_precal_sched.sv
// Builds A = H^T*H + snr*I and b = H^T*r with one shared MAC, one product per cycle.
module mmse_precal_sched #(
  parameter int DATA_W = mimo_pkg::DATA_W,
  parameter int N      = mimo_pkg::N
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  H_matrix,
  input  logic [N-1:0][DATA_W-1:0]         signal_receive,
  input  logic [DATA_W-1:0]                snr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N-1:0][N-1:0][DATA_W-1:0]  matrix_A,
  output logic [N-1:0][DATA_W-1:0]         vector_b,
  output logic                             busy
);
  import mimo_pkg::state_e;
  import mimo_pkg::IDLE;
  import mimo_pkg::COMPUTE;
  import mimo_pkg::DONE;
  import mimo_pkg::A_LEN;
  import mimo_pkg::B_LEN;

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(A_LEN + B_LEN);

  state_e r_state, w_next;

  logic [N-1:0][N-1:0][DATA_W-1:0] r_H;
  logic [N-1:0][DATA_W-1:0]        r_r;
  logic [DATA_W-1:0]               r_snr;
  logic [CW-1:0]                   r_cnt;
  logic [IW-1:0]                   r_i, r_j, r_k;
  logic [N-1:0][N-1:0][DATA_W-1:0] r_A;
  logic [N-1:0][DATA_W-1:0]        r_b;

  logic              w_xfer, w_step, w_phase_b, w_last_k, w_last;
  logic [DATA_W-1:0] w_opb, w_sum, w_val;

  assign w_xfer    = in_valid && (r_state == IDLE);
  assign w_step    = (r_state == COMPUTE);
  assign w_phase_b = (r_cnt >= CW'(A_LEN));
  assign w_last_k  = (r_k == IW'(N-1));
  assign w_last    = (r_cnt == CW'(A_LEN + B_LEN - 1));
  assign w_opb     = w_phase_b ? r_r[r_k] : r_H[r_k][r_j];
  assign w_val     = w_sum + ((r_i == r_j) ? r_snr : '0);

  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_k == '0),
    .i_en  (w_step),
    .i_a   (r_H[r_k][r_i]),
    .i_b   (w_opb),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = COMPUTE;
      COMPUTE: if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_H   <= '0;
      r_r   <= '0;
      r_snr <= '0;
    end else if (w_xfer) begin
      r_H   <= H_matrix;
      r_r   <= signal_receive;
      r_snr <= snr;
    end
  end

  // Walk (i,j,k) over the upper triangle, then (i,k) for b.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
    end else if (w_xfer) begin
      r_cnt <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CW'(1);
      r_k   <= r_k + IW'(1);
      if (w_last_k) begin
        if (w_phase_b) begin
          r_i <= r_i + IW'(1);
        end else if (r_j == IW'(N-1)) begin
          r_i <= (r_i == IW'(N-1)) ? '0 : r_i + IW'(1);
          r_j <= r_i + IW'(1);
        end else begin
          r_j <= r_j + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_A <= '0;
      r_b <= '0;
    end else if (w_step && w_last_k) begin
      if (w_phase_b) begin
        r_b[r_i] <= w_sum;
      end else begin
        r_A[r_i][r_j] <= w_val;
        r_A[r_j][r_i] <= w_val;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == COMPUTE);
  assign out_valid = (r_state == DONE);
  assign matrix_A  = r_A;
  assign vector_b  = r_b;
endmodule

// File: tb/tb_mmse_precal_sched.sv
// Directed checks of mmse_precal_sched: known matrices, latency, backpressure, reset abort.
module tb_mmse_precal_sched;
  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0][3:0][31:0] H_matrix, matrix_A;
  logic [3:0][31:0]      signal_receive, vector_b;
  logic [31:0]           snr;

  int checks = 0;
  int errors = 0;

  mmse_precal_sched dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .H_matrix       (H_matrix),
    .signal_receive (signal_receive),
    .snr            (snr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .matrix_A       (matrix_A),
    .vector_b       (vector_b),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [3:0][3:0][31:0] ea,
                         input logic [3:0][31:0] eb);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_A%0d%0d", tag, i, j), 64'(matrix_A[i][j]), 64'(ea[i][j]));
      chk($sformatf("%s_b%0d", tag, i), 64'(vector_b[i]), 64'(eb[i]));
    end
  endtask

  task automatic drive(input logic [3:0][3:0][31:0] h, input logic [3:0][31:0] r,
                       input logic [31:0] s);
    H_matrix = h;
    signal_receive = r;
    snr = s;
  endtask

  // Transfer happens at the posedge between the two negedges.
  task automatic start_set(input logic [3:0][3:0][31:0] h, input logic [3:0][31:0] r,
                           input logic [31:0] s);
    @(negedge clk);
    drive(h, r, s);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the transfer edge; out_valid is expected
  // to be seen by the 57th edge after transfer.
  task automatic wait_done(input string tag);
    int cnt;
    cnt = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_inrdy_lo"}, 64'(in_ready), 64'd0);
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'd57);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_inrdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_ov"}, 64'(out_valid), 64'd0);
  endtask

  logic [3:0][3:0][31:0] h_id, h_two, h_wrap, h_ns, ea_id, ea_two, ea_zero, ea_ns, h_junk;
  logic [3:0][31:0]      r_1234, r_one, r_zero, r_1001, eb_two, eb_ns;

  initial begin
    h_id = '0; h_two = '0; h_wrap = '0; h_ns = '0; h_junk = '0;
    ea_id = '0; ea_two = '0; ea_zero = '0; ea_ns = '0;
    for (int i = 0; i < 4; i++) begin
      h_id[i][i]  = 32'd1;
      ea_id[i][i] = 32'd6;
      r_1234[i] = 32'(i + 1);
      r_one[i]  = 32'd1;
      r_zero[i] = 32'd0;
      eb_two[i] = 32'd8;
      eb_ns[i]  = 32'(14 + 2 * i);
      for (int j = 0; j < 4; j++) begin
        h_two[i][j]  = 32'd2;
        ea_two[i][j] = (i == j) ? 32'd17 : 32'd16;
        h_ns[i][j]   = 32'(i * 4 + j + 1);
        h_junk[i][j] = 32'hdead_0000 + 32'(i * 4 + j);
      end
    end
    h_wrap[0][0] = 32'h0001_0000;
    r_1001 = '0;
    r_1001[0] = 32'd1;
    r_1001[3] = 32'd1;
    // Reference H^T*H for the non-symmetric case
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          ea_ns[i][j] = ea_ns[i][j] + h_ns[k][i] * h_ns[k][j];

    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(h_junk, r_1234, 32'd9);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_A_zero", 64'(|matrix_A), 64'd0);
    chk("rst_b_zero", 64'(|vector_b), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Identity H
    start_set(h_id, r_1234, 32'd5);
    drive(h_junk, r_zero, 32'd77);
    wait_done("ident");
    chk_res("ident", ea_id, r_1234);

    // Backpressure with a new set waiting on in_valid
    @(negedge clk);
    drive(h_two, r_one, 32'd1);
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk("hold_busy", 64'(busy), 64'd0);
    chk_res("hold", ea_id, r_1234);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_hs_inrdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("twos");
    chk_res("twos", ea_two, eb_two);
    handshake("twos");

    // Product wraps to zero
    start_set(h_wrap, r_zero, 32'd0);
    wait_done("wrap");
    chk_res("wrap", ea_zero, r_zero);
    handshake("wrap");

    // Abort mid-compute
    start_set(h_ns, r_1001, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_A_zero", 64'(|matrix_A), 64'd0);
    chk("abort_b_zero", 64'(|vector_b), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    start_set(h_two, r_one, 32'd1);
    wait_done("post_abort");
    chk_res("post_abort", ea_two, eb_two);
    handshake("post_abort");

    // Non-symmetric H
    start_set(h_ns, r_1001, 32'd0);
    wait_done("nonsym");
    chk_res("nonsym", ea_ns, eb_ns);
    chk("nonsym_A01", 64'(matrix_A[0][1]), 64'd304);
    handshake("nonsym");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmse_precal_sched.md
MMSE_PRECAL_SCHED -- requirements
Module: mmse_precal_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of every matrix/vector element, snr and accumulator.
REQ-002 SHALL have parameter N, default 4: antenna count (square H); only N=4 is required to be supported.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: a new H/r/snr set is presented.
REQ-006 SHALL have port in_ready, output, 1: block accepts a set.
REQ-007 SHALL have port H_matrix, input, N x N x DATA_W: channel matrix, [row][col].
REQ-008 SHALL have port signal_receive, input, N x DATA_W: received vector r.
REQ-009 SHALL have port snr, input, DATA_W: diagonal loading term.
REQ-010 SHALL have port out_valid, output, 1: matrix_A and vector_b are complete.
REQ-011 SHALL have port out_ready, input, 1: downstream solver consumes the result.
REQ-012 SHALL have port matrix_A, output, N x N x DATA_W: A = H^T*H + snr*I.
REQ-013 SHALL have port vector_b, output, N x DATA_W: b = H^T*r.
REQ-014 SHALL have port busy, output, 1: high in COMPUTE.

Function
REQ-015 SHALL be an FSM with states IDLE, COMPUTE, DONE.
REQ-016 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid && in_ready on a clock edge.
REQ-017 On transfer, SHALL latch H_matrix, signal_receive and snr into internal registers and enter COMPUTE; later input changes have no effect on the result.
REQ-018 SHALL compute with exactly one shared multiply-accumulate unit, one product per COMPUTE cycle.
REQ-019 Phase A: for i=0..3, j=i..3 (row-major, upper triangle, 10 entries), k=0..3: acc += H[k][i]*H[k][j]; 40 cycles.
REQ-020 At the end of each A entry, SHALL write acc (+snr if i==j) to matrix_A[i][j] and, if i!=j, to matrix_A[j][i] in the same cycle.
REQ-021 Phase B: for i=0..3, k=0..3: acc += H[k][i]*r[k]; write vector_b[i] at entry end; 16 cycles.
REQ-022 Accumulator SHALL clear at the first k of each entry; no carry between entries.
REQ-023 Arithmetic SHALL be unsigned two's-complement modulo 2^DATA_W: product truncated to its low DATA_W bits, sums wrap, no saturation.
REQ-024 COMPUTE SHALL last exactly 56 cycles; with transfer at edge T, out_valid SHALL be high from edge T+57.
REQ-025 In DONE, out_valid SHALL stay high and matrix_A/vector_b SHALL stay constant until out_valid && out_ready; then return to IDLE (in_ready high next cycle).
REQ-026 in_valid during COMPUTE or DONE SHALL be ignored (no transfer, no latching).
REQ-027 matrix_A/vector_b contents are defined only while out_valid; they are updated in place during COMPUTE.
REQ-028 Back-to-back: a new transfer SHALL be possible the cycle after the output handshake; minimum period 58 cycles.

Reset
REQ-029 reset low SHALL immediately force IDLE, clear all counters, accumulator and latched inputs, and drive out_valid=0, busy=0, matrix_A=0, vector_b=0; in_ready=1 after deassertion.
REQ-030 reset asserted mid-COMPUTE or in DONE SHALL discard the partial/complete result with no output handshake.

Structure
REQ-031 DATA_W, N, the FSM state enum and the phase-length constants (40, 16) SHALL live in shared package mimo_pkg.
REQ-032 The multiply-accumulate SHALL be a sub-module mac_unit (operands, clear, enable, registered acc).

Verification
REQ-033 H=identity, r=[1,2,3,4], snr=5 -> A diag 6, off-diag 0; b=[1,2,3,4]; out_valid exactly 57 cycles after transfer.
REQ-034 H all 2, r all 1, snr=1 -> A diag 17, off-diag 16; b=[8,8,8,8].
REQ-035 H[0][0]=0x00010000, all other H 0, snr=0 -> A[0][0]=0 (wrap); all other A, b 0.
REQ-036 out_ready low for 10 cycles after out_valid, in_valid held high with new data -> outputs stable, in_ready low, no transfer; then handshake -> IDLE, next set accepted.
REQ-037 reset low at cycle 20 of COMPUTE -> all outputs 0 immediately, in_ready 1 after release, next set gives correct result.
REQ-038 Non-symmetric H (H[i][j]=i*4+j+1), r=[1,0,0,1], snr=0 -> A equals golden H^T*H (symmetric), b[i]=H[0][i]+H[3][i].
